register_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write register file for the MIPS datapath.
- Provides WR_DEPTH write ports, RD_DEPTH combinational read ports, optional write-to-read bypass, and a hardwired zero register.
- Adds a per-register busy scoreboard: a reserve port marks a register pending, and a later write clears it. The issue stage uses this to detect RAW hazards without external bookkeeping.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/register_file_mp_if.sv | 28 ++
 rtl/regfile_wr_sel.sv | 34 +++
 rtl/register_file_mp.sv | 103 ++++++++++
 tb/tb_register_file_mp.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_DEPTH  = 32;
    localparam int ZERO_ADDR      = 0;

    function automatic int slice_off(input int idx, input int width);
        return idx * width;
    endfunction

    // True when more than one bit of the hit vector is set.
    function automatic logic multi_hit(input logic [31:0] hits);
        return (hits & (hits - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: write, read, reserve and status.
interface register_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_DEPTH   = 2,
    parameter int WR_DEPTH   = 2
);
    logic                           en_n;
    logic [WR_DEPTH-1:0]            wr;
    logic [ADDR_WIDTH*WR_DEPTH-1:0] rw;
    logic [DATA_WIDTH*WR_DEPTH-1:0] d;
    logic [ADDR_WIDTH*RD_DEPTH-1:0] rr;
    logic [DATA_WIDTH*RD_DEPTH-1:0] q;
    logic                           rsv;
    logic [ADDR_WIDTH-1:0]          rsv_addr;
    logic [RD_DEPTH-1:0]            busy;
    logic                           wr_conflict;

    modport master (
        output en_n, wr, rw, d, rr, rsv, rsv_addr,
        input  q, busy, wr_conflict
    );

    modport slave (
        input  en_n, wr, rw, d, rr, rsv, rsv_addr,
        output q, busy, wr_conflict
    );
endinterface

// File: rtl/regfile_wr_sel.sv
// Per-register write selector: priority-encodes the write ports that target ADDR.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter int          WR_DEPTH   = 2,
    parameter int unsigned ADDR       = 0
) (
    input  logic [WR_DEPTH-1:0]            wr_en,
    input  logic [ADDR_WIDTH*WR_DEPTH-1:0] rw,
    input  logic [DATA_WIDTH*WR_DEPTH-1:0] d,
    output logic                           hit,
    output logic [DATA_WIDTH-1:0]          data,
    output logic                           conflict
);
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(ADDR);

    logic [WR_DEPTH-1:0] hits;

    // Ascending scan so the highest-index hitting port overrides the rest.
    always_comb begin
        hits = '0;
        data = '0;
        for (int i = 0; i < WR_DEPTH; i++) begin
            hits[i] = wr_en[i] && (rw[slice_off(i, ADDR_WIDTH) +: ADDR_WIDTH] == MY_ADDR);
            if (hits[i]) data = d[slice_off(i, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    assign hit      = |hits;
    assign conflict = multi_hit(32'(hits));

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write bypass, zero register and busy scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_DEPTH   = 2,
    parameter int WR_DEPTH   = 2,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_mp_if.slave  bus
);
    localparam int NUM = 2 ** ADDR_WIDTH;

    // Writes and reserves are live only out of reset and with the enable asserted.
    logic                active;
    logic [WR_DEPTH-1:0] wr_gated;

    assign active   = rst_n && !bus.en_n;
    assign wr_gated = bus.wr & {WR_DEPTH{active}};

    logic [NUM*DATA_WIDTH-1:0] regs_flat;
    logic [NUM*DATA_WIDTH-1:0] wdata_flat;
    logic [NUM-1:0]            busy_bits;
    logic [NUM-1:0]            hit;
    logic [NUM-1:0]            conf;
    logic [NUM-1:0]            rsv_hit;
    logic                      conflict_q;

    for (genvar r = 0; r < NUM; r++) begin : g_reg
        if (r < REG_DEPTH && !(ZERO_REG && r == ZERO_ADDR)) begin : g_live
            logic [DATA_WIDTH-1:0] value;
            logic                  busy_bit;

            regfile_wr_sel #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .WR_DEPTH   (WR_DEPTH),
                .ADDR       (r)
            ) u_sel (
                .wr_en    (wr_gated),
                .rw       (bus.rw),
                .d        (bus.d),
                .hit      (hit[r]),
                .data     (wdata_flat[r*DATA_WIDTH +: DATA_WIDTH]),
                .conflict (conf[r])
            );

            assign rsv_hit[r] = active && bus.rsv && (bus.rsv_addr == ADDR_WIDTH'(r));

            // A reserve in the same cycle as a write keeps the register pending.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value    <= '0;
                    busy_bit <= 1'b0;
                end else begin
                    if (hit[r]) value <= wdata_flat[r*DATA_WIDTH +: DATA_WIDTH];
                    if (rsv_hit[r])  busy_bit <= 1'b1;
                    else if (hit[r]) busy_bit <= 1'b0;
                end
            end

            assign regs_flat[r*DATA_WIDTH +: DATA_WIDTH] = value;
            assign busy_bits[r] = busy_bit;
        end else begin : g_dead
            assign hit[r]     = 1'b0;
            assign conf[r]    = 1'b0;
            assign rsv_hit[r] = 1'b0;
            assign busy_bits[r] = 1'b0;
            assign regs_flat[r*DATA_WIDTH +: DATA_WIDTH]  = '0;
            assign wdata_flat[r*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 1'b0;
        else        conflict_q <= |conf;
    end

    assign bus.wr_conflict = conflict_q;

    always_comb begin
        logic [ADDR_WIDTH-1:0] addr;
        bus.q    = '0;
        bus.busy = '0;
        for (int j = 0; j < RD_DEPTH; j++) begin
            addr = bus.rr[slice_off(j, ADDR_WIDTH) +: ADDR_WIDTH];
            bus.q[slice_off(j, DATA_WIDTH) +: DATA_WIDTH] =
                regs_flat[slice_off(int'(addr), DATA_WIDTH) +: DATA_WIDTH];
            bus.busy[j] = busy_bits[addr];
            if (BYPASS && hit[addr]) begin
                bus.q[slice_off(j, DATA_WIDTH) +: DATA_WIDTH] =
                    wdata_flat[slice_off(int'(addr), DATA_WIDTH) +: DATA_WIDTH];
                if (!rsv_hit[addr]) bus.busy[j] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: reset, bypass, conflict, zero reg, scoreboard, enable.
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_DEPTH(2), .WR_DEPTH(2)) bus ();

    register_file_mp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] q0();
        return bus.q[31:0];
    endfunction

    function automatic logic [31:0] q1();
        return bus.q[63:32];
    endfunction

    initial begin
        rst_n        = 1'b0;
        bus.en_n     = 1'b0;
        bus.wr       = 2'b11;
        bus.rw       = {5'd4, 5'd27};
        bus.d        = {32'h37373737, 32'hdcaf484c};
        bus.rr       = {5'd27, 5'd4};
        bus.rsv      = 1'b0;
        bus.rsv_addr = 5'd0;

        // Reset with write attempts applied
        settle();
        check("rst_q0", q0(), 32'h0);
        check("rst_q1", q1(), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_conflict", 32'(bus.wr_conflict), 32'h0);
        tick();
        tick();
        check("rst_q0_held", q0(), 32'h0);
        check("rst_q1_held", q1(), 32'h0);
        bus.wr = 2'b00;
        rst_n  = 1'b1;
        settle();
        check("post_rst_q1", q1(), 32'h0);

        // Dual write with same-cycle bypass
        bus.wr = 2'b11;
        settle();
        check("byp_q1_r27", q1(), 32'hdcaf484c);
        check("byp_q0_r4", q0(), 32'h37373737);
        tick();
        bus.wr = 2'b00;
        settle();
        check("hold_q1_r27", q1(), 32'hdcaf484c);
        check("hold_q0_r4", q0(), 32'h37373737);
        check("no_conflict", 32'(bus.wr_conflict), 32'h0);

        // Conflict on address 9: port 1 wins
        bus.wr = 2'b11;
        bus.rw = {5'd9, 5'd9};
        bus.d  = {32'h22222222, 32'h11111111};
        bus.rr = {5'd27, 5'd9};
        settle();
        check("conf_byp_q0", q0(), 32'h22222222);
        tick();
        bus.wr = 2'b00;
        settle();
        check("conf_pulse", 32'(bus.wr_conflict), 32'h1);
        check("conf_r9", q0(), 32'h22222222);
        tick();
        check("conf_clear", 32'(bus.wr_conflict), 32'h0);

        // Zero register ignores writes and reserves
        bus.wr       = 2'b10;
        bus.rw       = {5'd0, 5'd0};
        bus.d        = {32'hffffffff, 32'h0};
        bus.rsv      = 1'b1;
        bus.rsv_addr = 5'd0;
        bus.rr       = {5'd4, 5'd0};
        settle();
        check("zero_byp_q0", q0(), 32'h0);
        check("zero_byp_busy", 32'(bus.busy[0]), 32'h0);
        tick();
        bus.wr  = 2'b00;
        bus.rsv = 1'b0;
        settle();
        check("zero_q0", q0(), 32'h0);
        check("zero_busy", 32'(bus.busy[0]), 32'h0);
        check("zero_r4_kept", q1(), 32'h37373737);

        // Scoreboard on register 12
        bus.rr       = {5'd12, 5'd12};
        bus.rsv      = 1'b1;
        bus.rsv_addr = 5'd12;
        tick();
        bus.rsv = 1'b0;
        settle();
        check("sb_busy_set0", 32'(bus.busy[0]), 32'h1);
        check("sb_busy_set1", 32'(bus.busy[1]), 32'h1);
        bus.wr = 2'b01;
        bus.rw = {5'd0, 5'd12};
        bus.d  = {32'h0, 32'ha5a5a5a5};
        settle();
        check("sb_byp_busy", 32'(bus.busy[0]), 32'h0);
        check("sb_byp_q", q0(), 32'ha5a5a5a5);
        tick();
        bus.wr = 2'b00;
        settle();
        check("sb_cleared", 32'(bus.busy[0]), 32'h0);
        check("sb_q", q1(), 32'ha5a5a5a5);
        bus.rsv = 1'b1;
        tick();
        bus.wr = 2'b01;
        bus.d  = {32'h0, 32'h5a5a5a5a};
        settle();
        check("sb_rsvwr_comb_busy", 32'(bus.busy[0]), 32'h1);
        tick();
        bus.wr  = 2'b00;
        bus.rsv = 1'b0;
        settle();
        check("sb_rsvwr_busy", 32'(bus.busy[0]), 32'h1);
        check("sb_rsvwr_q", q0(), 32'h5a5a5a5a);

        // Enable gate on address 5
        bus.en_n     = 1'b1;
        bus.wr       = 2'b11;
        bus.rw       = {5'd5, 5'd5};
        bus.d        = {32'hcafef00d, 32'h12345678};
        bus.rsv      = 1'b1;
        bus.rsv_addr = 5'd5;
        bus.rr       = {5'd27, 5'd5};
        settle();
        check("en_byp_off_q0", q0(), 32'h0);
        check("en_busy_comb", 32'(bus.busy[0]), 32'h0);
        tick();
        settle();
        check("en_q0", q0(), 32'h0);
        check("en_busy", 32'(bus.busy[0]), 32'h0);
        check("en_conflict", 32'(bus.wr_conflict), 32'h0);
        check("en_r27_kept", q1(), 32'hdcaf484c);
        bus.en_n = 1'b0;
        bus.wr   = 2'b00;
        bus.rsv  = 1'b0;
        settle();
        check("en_after_busy", 32'(bus.busy[0]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
